mp_commit_watchdog: RTL and testbench

Synthesizable bench-side checker for multi-port CPU designs (mp2+ with split I/D memory). It is the next generation of the mp1 top-level bench logic, with these duties:
- counts retired instructions (RVFI order);
- detects halt (self-loop PC) with a configurable repeat count;
- runs a commit-based stall watchdog;
- runs a per-port memory handshake protocol FSM, generalised to NUM_PORTS ports.

All findings are reported through a sticky errcode/err_port pair that the top-level bench uses to call $finish.

---
 rtl/mp_commit_watchdog.sv | 165 ++++++++++++++++
 tb/tb_mp_commit_watchdog.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mp_commit_watchdog.sv
// mp_commit_watchdog: retire counter, halt detector, commit watchdog and
// per-port memory handshake checker for multi-port CPU benches.
module mp_commit_watchdog #(
  parameter int unsigned NUM_PORTS   = 2,
  parameter int unsigned ORDER_W     = 64,
  parameter int unsigned WDOG_W      = 32,
  parameter int unsigned WDOG_CYCLES = 10000,
  parameter int unsigned HALT_REPEAT = 1,
  localparam int unsigned PORT_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    commit,
  input  logic [31:0]             pc_rdata,
  input  logic [31:0]             pc_wdata,
  input  logic [NUM_PORTS-1:0]    mem_read,
  input  logic [NUM_PORTS-1:0]    mem_write,
  input  logic [NUM_PORTS-1:0]    mem_resp,
  input  logic [32*NUM_PORTS-1:0] mem_address,
  output logic [ORDER_W-1:0]      order,
  output logic                    halt,
  output logic                    timeout,
  output logic [3:0]              errcode,
  output logic [PORT_W-1:0]       err_port,
  output logic                    done
);

  localparam int unsigned        STREAK_W    = $clog2(HALT_REPEAT + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(HALT_REPEAT);
  localparam logic [WDOG_W-1:0]   WDOG_RELOAD = WDOG_W'(WDOG_CYCLES);

  localparam logic [3:0] ERR_RW   = 4'd1;
  localparam logic [3:0] ERR_DROP = 4'd2;
  localparam logic [3:0] ERR_SPUR = 4'd3;
  localparam logic [3:0] ERR_ADDR = 4'd4;
  localparam logic [3:0] ERR_WDOG = 4'd5;

  typedef enum logic [1:0] {IDLE, READ, WRITE} port_state_t;

  port_state_t         state    [NUM_PORTS];
  logic [31:0]         lat_addr [NUM_PORTS];
  logic [3:0]          port_err [NUM_PORTS];
  logic [STREAK_W-1:0] streak;
  logic [STREAK_W-1:0] streak_nxt;
  logic [WDOG_W-1:0]   wdog;
  logic                wdog_expire;
  logic [3:0]          first_err;
  logic [PORT_W-1:0]   first_port;

  // Halt streak update and watchdog expiry condition
  always_comb begin
    streak_nxt = streak;
    if (commit) begin
      if (pc_rdata != pc_wdata) begin
        streak_nxt = '0;
      end else if (streak != STREAK_MAX) begin
        streak_nxt = streak + STREAK_W'(1);
      end
    end
    wdog_expire = !halt && !commit && (wdog == WDOG_W'(1));
  end

  // Per-port protocol violation, highest-priority code within the port
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      port_err[i] = '0;
      case (state[i])
        IDLE: begin
          if (mem_read[i] && mem_write[i]) port_err[i] = ERR_RW;
          else if (mem_resp[i])            port_err[i] = ERR_SPUR;
        end
        READ: begin
          if (mem_write[i])                      port_err[i] = ERR_RW;
          else if (!mem_read[i] && !mem_resp[i]) port_err[i] = ERR_DROP;
          else if (mem_read[i] && (mem_address[32*i +: 32] != lat_addr[i]))
            port_err[i] = ERR_ADDR;
        end
        WRITE: begin
          if (mem_read[i])                        port_err[i] = ERR_RW;
          else if (!mem_write[i] && !mem_resp[i]) port_err[i] = ERR_DROP;
          else if (mem_write[i] && (mem_address[32*i +: 32] != lat_addr[i]))
            port_err[i] = ERR_ADDR;
        end
        default: port_err[i] = '0;
      endcase
    end
  end

  // Lowest-index port with an error wins
  always_comb begin
    first_err  = '0;
    first_port = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (port_err[i] != '0) begin
        first_err  = port_err[i];
        first_port = PORT_W'(i);
      end
    end
  end

  // Port handshake FSMs; a request both read and write from IDLE is not started
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        state[i]    <= IDLE;
        lat_addr[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        case (state[i])
          IDLE: begin
            if (mem_read[i] && !mem_write[i]) begin
              state[i]    <= READ;
              lat_addr[i] <= mem_address[32*i +: 32];
            end else if (mem_write[i] && !mem_read[i]) begin
              state[i]    <= WRITE;
              lat_addr[i] <= mem_address[32*i +: 32];
            end
          end
          READ:    if (mem_resp[i] || !mem_read[i])  state[i] <= IDLE;
          WRITE:   if (mem_resp[i] || !mem_write[i]) state[i] <= IDLE;
          default: state[i] <= IDLE;
        endcase
      end
    end
  end

  // Retire order, halt, watchdog and sticky first-error capture
  always_ff @(posedge clk) begin
    if (rst) begin
      order    <= '0;
      halt     <= 1'b0;
      timeout  <= 1'b0;
      errcode  <= '0;
      err_port <= '0;
      wdog     <= WDOG_RELOAD;
      streak   <= '0;
    end else begin
      if (commit) order <= order + ORDER_W'(1);
      streak <= streak_nxt;
      if (streak_nxt == STREAK_MAX) halt <= 1'b1;
      if (!halt) begin
        if (commit) begin
          wdog <= WDOG_RELOAD;
        end else if (wdog_expire) begin
          wdog    <= '0;
          timeout <= 1'b1;
        end else if (wdog != '0) begin
          wdog <= wdog - WDOG_W'(1);
        end
      end
      if (errcode == '0) begin
        if (first_err != '0) begin
          errcode  <= first_err;
          err_port <= first_port;
        end else if (wdog_expire) begin
          errcode  <= ERR_WDOG;
        end
      end
    end
  end

  assign done = halt | timeout | (errcode != '0);

endmodule

// File: tb/tb_mp_commit_watchdog.sv
// Self-checking bench for mp_commit_watchdog: directed scenarios plus a
// randomized phase, checked against an event-level reference model.
module tb_mp_commit_watchdog;

  localparam int NP = 2;
  localparam int OW = 64;
  localparam int WW = 32;
  localparam int WD = 10;
  localparam int HR = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             commit = 1'b0;
  logic [31:0]      pc_rdata = '0;
  logic [31:0]      pc_wdata = '0;
  logic [NP-1:0]    mem_read = '0;
  logic [NP-1:0]    mem_write = '0;
  logic [NP-1:0]    mem_resp = '0;
  logic [32*NP-1:0] mem_address = '0;
  logic [OW-1:0]    order;
  logic             halt;
  logic             timeout;
  logic [3:0]       errcode;
  logic [0:0]       err_port;
  logic             done;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  longint unsigned m_order;
  int              m_streak;
  int              m_idle;
  bit              m_halt;
  bit              m_timeout;
  int              m_err;
  int              m_eport;
  int              m_busy [NP];   // 0 none, 1 read pending, 2 write pending
  logic [31:0]     m_addr [NP];

  // Random driver state
  bit          d_act  [NP];
  bit          d_wr   [NP];
  logic [31:0] d_addr [NP];

  mp_commit_watchdog #(
    .NUM_PORTS(NP), .ORDER_W(OW), .WDOG_W(WW),
    .WDOG_CYCLES(WD), .HALT_REPEAT(HR)
  ) dut (
    .clk(clk), .rst(rst), .commit(commit), .pc_rdata(pc_rdata),
    .pc_wdata(pc_wdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_resp(mem_resp), .mem_address(mem_address), .order(order),
    .halt(halt), .timeout(timeout), .errcode(errcode),
    .err_port(err_port), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_order = 0; m_streak = 0; m_idle = 0;
    m_halt = 0; m_timeout = 0; m_err = 0; m_eport = 0;
    for (int p = 0; p < NP; p++) begin
      m_busy[p] = 0;
      m_addr[p] = '0;
    end
  endtask

  // Advance the model by one cycle from the currently driven inputs
  task automatic model_step();
    bit expired;
    int code [NP];
    if (rst) begin
      model_reset();
      return;
    end
    expired = 0;
    if (!m_halt) begin
      if (commit) m_idle = 0;
      else if (m_idle < WD) begin
        m_idle++;
        expired = (m_idle == WD);
      end
    end
    if (commit) begin
      m_order++;
      if (pc_rdata == pc_wdata) m_streak = (m_streak < HR) ? m_streak + 1 : HR;
      else                      m_streak = 0;
      if (m_streak == HR) m_halt = 1;
    end
    for (int p = 0; p < NP; p++) begin
      bit rd, wr, rs, own, opp;
      logic [31:0] a;
      rd = mem_read[p]; wr = mem_write[p]; rs = mem_resp[p];
      a  = mem_address[32*p +: 32];
      code[p] = 0;
      if (m_busy[p] == 0) begin
        if (rd && wr) code[p] = 1;
        else if (rs)  code[p] = 3;
        if (rd != wr) begin
          m_busy[p] = rd ? 1 : 2;
          m_addr[p] = a;
        end
      end else begin
        own = (m_busy[p] == 1) ? rd : wr;
        opp = (m_busy[p] == 1) ? wr : rd;
        if (opp)                          code[p] = 1;
        else if (!own && !rs)             code[p] = 2;
        else if (own && a != m_addr[p])   code[p] = 4;
        if (rs || !own) m_busy[p] = 0;
      end
    end
    if (expired) m_timeout = 1;
    if (m_err == 0) begin
      for (int p = NP - 1; p >= 0; p--) begin
        if (code[p] != 0) begin
          m_err = code[p];
          m_eport = p;
        end
      end
      if (m_err == 0 && expired) begin
        m_err = 5;
        m_eport = 0;
      end
    end
  endtask

  // One clock: check pre-edge order, update model, clock, check outputs
  task automatic step();
    if (!rst) check("order_pre", order, m_order);
    model_step();
    @(posedge clk);
    #1;
    check("order", order, m_order);
    check("halt", halt, 64'(m_halt));
    check("timeout", timeout, 64'(m_timeout));
    check("errcode", errcode, 64'(m_err));
    check("err_port", err_port, 64'(m_eport));
    check("done", done, 64'(m_halt | m_timeout | (m_err != 0)));
  endtask

  task automatic clr();
    commit = 0; pc_rdata = '0; pc_wdata = '0;
    mem_read = '0; mem_write = '0; mem_resp = '0; mem_address = '0;
  endtask

  task automatic do_reset();
    rst = 1;
    clr();
    repeat (3) step();
    rst = 0;
    for (int p = 0; p < NP; p++) d_act[p] = 0;
  endtask

  task automatic do_commit(input logic [31:0] from, input logic [31:0] to);
    commit = 1; pc_rdata = from; pc_wdata = to;
    step();
    clr();
  endtask

  // Randomized, mostly protocol-legal traffic with occasional faults
  task automatic rand_cycle();
    logic [NP-1:0] rd, wr, rs;
    logic [32*NP-1:0] ad;
    int r;
    rd = '0; wr = '0; rs = '0; ad = '0;
    rst    = ($urandom_range(0, 59) == 0);
    commit = ($urandom_range(0, 3) == 0);
    pc_rdata = $urandom;
    pc_wdata = ($urandom_range(0, 5) == 0) ? pc_rdata : pc_rdata + 32'd4;
    for (int p = 0; p < NP; p++) begin
      if (d_act[p]) begin
        rd[p] = !d_wr[p];
        wr[p] = d_wr[p];
        ad[32*p +: 32] = d_addr[p];
        rs[p] = ($urandom_range(0, 2) == 0);
        r = $urandom_range(0, 39);
        if (r == 0) begin
          rd[p] = 0; wr[p] = 0; rs[p] = 0;
        end else if (r == 1) begin
          ad[32*p +: 32] = d_addr[p] ^ 32'h4;
        end else if (r == 2) begin
          rd[p] = 1; wr[p] = 1;
        end
        if (rs[p] || (!rd[p] && !wr[p])) d_act[p] = 0;
      end else begin
        r = $urandom_range(0, 29);
        if (r < 10) begin
          d_act[p]  = 1;
          d_wr[p]   = (r >= 5);
          d_addr[p] = $urandom & 32'hFFFF_FFFC;
          rd[p] = !d_wr[p];
          wr[p] = d_wr[p];
          ad[32*p +: 32] = d_addr[p];
        end else if (r == 10) begin
          rs[p] = 1;
        end
      end
      if (rst) d_act[p] = 0;
    end
    mem_read = rd; mem_write = wr; mem_resp = rs; mem_address = ad;
    step();
  endtask

  initial begin
    model_reset();
    for (int p = 0; p < NP; p++) d_act[p] = 0;

    // Reset, then five ordinary commits
    do_reset();
    check("rst_order", order, 64'd0);
    check("rst_errcode", errcode, 64'd0);
    for (int k = 0; k < 5; k++) begin
      commit = 1; pc_rdata = 32'h60 + 32'(4 * k); pc_wdata = pc_rdata + 32'd4;
      check("order_k", order, 64'(k));
      step();
    end
    clr();
    check("order_after5", order, 64'd5);
    check("no_halt", halt, 64'd0);
    check("no_err", errcode, 64'd0);

    // Halt after two consecutive self-loop commits, then watchdog frozen
    do_reset();
    do_commit(32'h80, 32'h80);
    do_commit(32'h84, 32'h88);
    do_commit(32'h88, 32'h88);
    check("halt_early", halt, 64'd0);
    do_commit(32'h88, 32'h88);
    check("halt_set", halt, 64'd1);
    repeat (15) step();
    check("halt_sticky", halt, 64'd1);
    check("wdog_frozen", timeout, 64'd0);

    // Watchdog expires on the 10th edge after the last commit
    do_reset();
    do_commit(32'h10, 32'h14);
    repeat (9) step();
    check("wdog_pre", timeout, 64'd0);
    step();
    check("wdog_tmo", timeout, 64'd1);
    check("wdog_code", errcode, 64'd5);

    // Commit in the last cycle reloads the watchdog
    do_reset();
    do_commit(32'h10, 32'h14);
    repeat (9) step();
    do_commit(32'h14, 32'h18);
    repeat (5) step();
    check("wdog_reload", timeout, 64'd0);

    // Legal read on port 1, then same-cycle errors on ports 0 and 1
    do_reset();
    mem_read = 2'b10; mem_address[63:32] = 32'h100;
    repeat (3) step();
    mem_resp = 2'b10;
    step();
    clr();
    step();
    check("legal_read", errcode, 64'd0);
    mem_read = 2'b01; mem_write = 2'b01; mem_resp = 2'b10;
    step();
    clr();
    check("rw_code", errcode, 64'd1);
    check("rw_port", err_port, 64'd0);

    // Address change on port 0, later drop on port 1 does not overwrite
    do_reset();
    mem_read = 2'b01; mem_address[31:0] = 32'h200;
    step();
    mem_address[31:0] = 32'h204;
    step();
    clr();
    check("addr_code", errcode, 64'd4);
    mem_write = 2'b10; mem_address[63:32] = 32'h300;
    step();
    clr();
    step();
    check("addr_sticky", errcode, 64'd4);
    check("addr_port", err_port, 64'd0);

    // Dropped write on port 1
    do_reset();
    mem_write = 2'b10; mem_address[63:32] = 32'h300;
    step();
    clr();
    step();
    check("drop_code", errcode, 64'd2);
    check("drop_port", err_port, 64'd1);

    // Reset in the middle of a transaction raises nothing
    do_reset();
    do_commit(32'h40, 32'h44);
    do_commit(32'h44, 32'h48);
    mem_read = 2'b01; mem_address[31:0] = 32'h500;
    step();
    rst = 1;
    step();
    rst = 0;
    clr();
    repeat (2) step();
    check("rst_mid_err", errcode, 64'd0);
    check("rst_mid_order", order, 64'd0);

    // Randomized traffic
    do_reset();
    repeat (3000) rand_cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
